// File: rtl/comparator_tree_pipe_if.sv
// Operand/result bundle with valid/ready handshake for comparator_tree_pipe.
// The master supplies operands and consumes results; the slave is the compare pipe.
interface comparator_tree_pipe_if #(
    parameter int WIDTH = 64
);
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             OutValid;
    logic             OutReady;
    logic             EQ;
    logic             LT;
    logic             LTu;

    modport master (
        output Flush, InValid, A, B, OutReady,
        input  InReady, OutValid, EQ, LT, LTu
    );

    modport slave (
        input  Flush, InValid, A, B, OutReady,
        output InReady, OutValid, EQ, LT, LTu
    );
endinterface

// File: rtl/comparator_tree_pipe.sv
// Pipelined EQ / signed LT / unsigned LTu comparator tree with elastic valid/ready flow.
// Tree levels are spread over STAGES register stages; flush and stalls act on all stages.
module comparator_tree_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    comparator_tree_pipe_if.slave bus
);
    localparam int L    = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    // Unsigned (lt,gt) vector shared by both chains, plus the signed copy of the top branch only.
    typedef struct packed {
        logic [HALF-1:0] lt;
        logic [HALF-1:0] gt;
        logic            slt;
        logic            sgt;
    } node_t;

    function automatic node_t merge_level(input node_t n, input int j);
        node_t r;
        int    top_lo;
        r = '0;
        for (int i = 0; i < HALF / 2; i++) begin
            r.gt[i] = n.gt[2*i+1] | (~n.lt[2*i+1] & n.gt[2*i]);
            r.lt[i] = n.lt[2*i+1] | (~n.gt[2*i+1] & n.lt[2*i]);
        end
        top_lo = (HALF >> (j - 1)) - 2;
        r.sgt = n.sgt | (~n.slt & n.gt[top_lo]);
        r.slt = n.slt | (~n.sgt & n.lt[top_lo]);
        return r;
    endfunction

    node_t              leaf;
    node_t [STAGES-1:0] stage_node;
    logic  [STAGES-1:0] stage_valid;
    logic  [STAGES-1:0] advance;

    always_comb begin
        leaf = '0;
        for (int i = 0; i < HALF; i++) begin
            leaf.lt[i] = bus.A[2*i +: 2] < bus.B[2*i +: 2];
            leaf.gt[i] = bus.A[2*i +: 2] > bus.B[2*i +: 2];
        end
        leaf.slt = {~bus.A[WIDTH-1], bus.A[WIDTH-2]} < {~bus.B[WIDTH-1], bus.B[WIDTH-2]};
        leaf.sgt = {~bus.A[WIDTH-1], bus.A[WIDTH-2]} > {~bus.B[WIDTH-1], bus.B[WIDTH-2]};
    end

    // A stage may move when any stage at or downstream of it has room, or the consumer takes.
    always_comb begin : p_advance
        logic all_full;
        all_full = 1'b1;
        advance  = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            all_full   = all_full & stage_valid[s];
            advance[s] = bus.OutReady | ~all_full;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = (s * L + STAGES - 1) / STAGES;
        localparam int HI = ((s + 1) * L + STAGES - 1) / STAGES - 1;

        node_t in_node;
        node_t merged;
        node_t node_d;
        node_t node_q;
        logic  in_valid;
        logic  valid_d;
        logic  valid_q;

        if (s == 0) begin : g_src
            assign in_node  = leaf;
            assign in_valid = bus.InValid;
        end else begin : g_src
            assign in_node  = stage_node[s-1];
            assign in_valid = stage_valid[s-1];
        end

        always_comb begin
            merged = in_node;
            for (int j = 1; j < L; j++) begin
                if (j >= LO && j <= HI) begin
                    merged = merge_level(merged, j);
                end
            end
            node_d  = advance[s] ? merged : node_q;
            valid_d = bus.Flush ? 1'b0 : (advance[s] ? in_valid : valid_q);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                node_q  <= '0;
            end else begin
                valid_q <= valid_d;
                node_q  <= node_d;
            end
        end

        assign stage_valid[s] = valid_q;
        assign stage_node[s]  = node_q;
    end

    assign bus.InReady  = advance[0] | bus.Flush;
    assign bus.OutValid = stage_valid[STAGES-1];
    assign bus.LTu      = stage_node[STAGES-1].lt[0];
    assign bus.LT       = stage_node[STAGES-1].slt;
    // Gated with valid so EQ reads 0 out of reset, when both lt and gt are clear.
    assign bus.EQ       = stage_valid[STAGES-1]
                        & ~(stage_node[STAGES-1].lt[0] | stage_node[STAGES-1].gt[0]);

    logic unused_tail;
    assign unused_tail = ^{stage_node[STAGES-1].lt[HALF-1:1],
                           stage_node[STAGES-1].gt[HALF-1:1],
                           stage_node[STAGES-1].sgt};
endmodule
